// File: rtl/ram_arbiter2.sv
// ram_arbiter2: round-robin arbiter sequencing two clients onto a 16x8 registered-read RAM
module ram_arbiter2 (
  input  logic       clock,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [3:0] addr_a,
  input  logic [3:0] addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rvalid_a,
  output logic       rvalid_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       ram_wen,
  output logic       ram_ren,
  output logic [3:0] ram_waddr,
  output logic [3:0] ram_raddr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_dout
);
  logic       ptr, rv_a, rv_b, any, sel_we;
  logic [3:0] sel_addr;
  logic [7:0] sel_wdata;
  assign gnt_a = req_a & ~rst & (~req_b | ~ptr);
  assign gnt_b = req_b & ~rst & (~req_a | ptr);
  always_comb begin
    any       = gnt_a | gnt_b;
    sel_we    = gnt_a ? we_a : we_b;
    sel_addr  = gnt_a ? addr_a : addr_b;
    sel_wdata = gnt_a ? wdata_a : wdata_b;
    ram_wen   = any & sel_we;
    ram_ren   = any & ~sel_we;
    ram_waddr = ram_wen ? sel_addr : 4'd0;
    ram_raddr = ram_ren ? sel_addr : 4'd0;
    ram_wdata = ram_wen ? sel_wdata : 8'd0;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      ptr  <= 1'b0;
      rv_a <= 1'b0;
      rv_b <= 1'b0;
    end else begin
      ptr  <= gnt_a ? 1'b1 : gnt_b ? 1'b0 : ptr;
      rv_a <= gnt_a & ~we_a;
      rv_b <= gnt_b & ~we_b;
    end
  end
  assign rvalid_a = rv_a;
  assign rvalid_b = rv_b;
  assign rdata_a  = rv_a ? ram_dout : 8'd0;
  assign rdata_b  = rv_b ? ram_dout : 8'd0;
endmodule
